// File: rtl/int_pkg.sv
// Shared types and constants for the interrupt arbiter.
// State encoding, cause-code constants and counter widths.
package int_pkg;

  localparam int NSRC_MAX = 3;
  localparam int HOLD_W   = 3;

  localparam logic [1:0] CODE_NONE = 2'b00;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BREAK = 2'b01,
    HOLD  = 2'b10
  } state_e;

endpackage

// File: rtl/int_prio_enc.sv
// Highest-set-bit encoder: bit i reports code i+1 plus its one-hot mask.
// Ports: in_vec (N) -> out_vld, out_code (2), out_oh (N).
module int_prio_enc
  import int_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0] in_vec,
  output logic         out_vld,
  output logic [1:0]   out_code,
  output logic [N-1:0] out_oh
);

  always_comb begin
    out_vld  = 1'b0;
    out_code = CODE_NONE;
    out_oh   = '0;
    for (int i = 0; i < N; i++) begin
      if (in_vec[i]) begin
        out_vld   = 1'b1;
        out_code  = 2'(i + 1);
        out_oh    = '0;
        out_oh[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_arbiter.sv
// Interrupt arbiter: edge-latched pending, mask, priority pick, break FSM.
// Ports: in_CLK/in_RST, in_req, in_mask_we/in_mask, in_ie, in_ready,
// in_eret -> out_BK, out_code, out_pending, out_isr, out_busy.
// Option: INT_NEST_EN allows higher-priority preemption of a handler.
module int_arbiter
  import int_pkg::*;
#(
  parameter int NSRC     = 3,
  parameter int HOLD_CYC = 2
) (
  input  logic            in_CLK,
  input  logic            in_RST,
  input  logic [NSRC-1:0] in_req,
  input  logic            in_mask_we,
  input  logic [NSRC-1:0] in_mask,
  input  logic            in_ie,
  input  logic            in_ready,
  input  logic            in_eret,
  output logic            out_BK,
  output logic [1:0]      out_code,
  output logic [NSRC-1:0] out_pending,
  output logic [NSRC-1:0] out_isr,
  output logic            out_busy
);

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   cnt_q, cnt_d;
  logic [NSRC-1:0]     req_q, req_d;
  logic [NSRC-1:0]     pend_q, pend_d;
  logic [NSRC-1:0]     mask_q, mask_d;
  logic [NSRC-1:0]     isr_q, isr_d;
  logic                bk_q, bk_d;
  logic [1:0]          code_q, code_d;
  logic                busy_q, busy_d;

  logic [NSRC-1:0]     rise;
  logic                cand_vld, isr_vld;
  logic [1:0]          cand_code, isr_code;
  logic [NSRC-1:0]     cand_oh, isr_oh;
  logic                cand_ok, go;

  int_prio_enc #(.N(NSRC)) u_cand (
    .in_vec   (pend_q & mask_q),
    .out_vld  (cand_vld),
    .out_code (cand_code),
    .out_oh   (cand_oh)
  );

  int_prio_enc #(.N(NSRC)) u_lvl (
    .in_vec   (isr_q),
    .out_vld  (isr_vld),
    .out_code (isr_code),
    .out_oh   (isr_oh)
  );

  always_comb begin
    rise = in_req & ~req_q;
    // Only the top eligible source matters: if it
    // cannot beat cur_lvl, no lower one can either.
    cand_ok = cand_vld && (cand_code > isr_code);
`ifndef INT_NEST_EN
    cand_ok = cand_ok && !isr_vld;
`endif
    go = (state_q == IDLE) && in_ie && in_ready && cand_ok;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (go) state_d = BREAK;
      end
      BREAK: begin
        state_d = HOLD;
        cnt_d   = HOLD_W'(HOLD_CYC - 1);
      end
      HOLD: begin
        if (cnt_q == '0) state_d = IDLE;
        else cnt_d = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_d  = in_req;
    mask_d = in_mask_we ? in_mask : mask_q;
    // A fresh edge on the bit being cleared wins.
    pend_d = (pend_q & ~({NSRC{go}} & cand_oh)) | rise;
    // Pop acts on the old isr, then the push lands.
    isr_d  = isr_q & ~({NSRC{in_eret & isr_vld}} & isr_oh);
    isr_d  = isr_d | ({NSRC{go}} & cand_oh);
    bk_d   = go;
    code_d = go ? cand_code : CODE_NONE;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge in_CLK) begin
    if (in_RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      pend_q  <= '0;
      mask_q  <= '1;
      isr_q   <= '0;
      bk_q    <= 1'b0;
      code_q  <= CODE_NONE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      isr_q   <= isr_d;
      bk_q    <= bk_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
    end
  end

  assign out_BK      = bk_q;
  assign out_code    = code_q;
  assign out_pending = pend_q;
  assign out_isr     = isr_q;
  assign out_busy    = busy_q;

endmodule

// File: tb/tb_int_arbiter.sv
// Bench for int_arbiter: directed scenarios plus random traffic
// checked each cycle against a cycle-level behavioural model.
module tb_int_arbiter;

  localparam int NSRC     = 3;
  localparam int HOLD_CYC = 2;

  logic            in_CLK = 1'b0;
  logic            in_RST;
  logic [NSRC-1:0] in_req;
  logic            in_mask_we;
  logic [NSRC-1:0] in_mask;
  logic            in_ie;
  logic            in_ready;
  logic            in_eret;
  logic            out_BK;
  logic [1:0]      out_code;
  logic [NSRC-1:0] out_pending;
  logic [NSRC-1:0] out_isr;
  logic            out_busy;

  int_arbiter #(.NSRC(NSRC), .HOLD_CYC(HOLD_CYC)) dut (
    .in_CLK      (in_CLK),
    .in_RST      (in_RST),
    .in_req      (in_req),
    .in_mask_we  (in_mask_we),
    .in_mask     (in_mask),
    .in_ie       (in_ie),
    .in_ready    (in_ready),
    .in_eret     (in_eret),
    .out_BK      (out_BK),
    .out_code    (out_code),
    .out_pending (out_pending),
    .out_isr     (out_isr),
    .out_busy    (out_busy)
  );

  always #5 in_CLK = ~in_CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // model state: plain per-source arrays and a blanking countdown
  int m_req[NSRC], m_pend[NSRC], m_mask[NSRC], m_isr[NSRC];
  int m_left;
  int e_bk, e_code;

  function automatic logic [31:0] pack(input int a[NSRC]);
    logic [31:0] v = 0;
    for (int i = 0; i < NSRC; i++) if (a[i] != 0) v = v + (1 << i);
    return v;
  endfunction

  task automatic model_step();
    int lvl, cand, ok, rq;
    if (in_RST) begin
      for (int i = 0; i < NSRC; i++) begin
        m_req[i] = 0; m_pend[i] = 0; m_mask[i] = 1; m_isr[i] = 0;
      end
      m_left = 0; e_bk = 0; e_code = 0;
      return;
    end
    lvl = 0; cand = 0;
    for (int i = 0; i < NSRC; i++) begin
      if (m_isr[i] != 0) lvl = i + 1;
      if (m_pend[i] != 0 && m_mask[i] != 0) cand = i + 1;
    end
    ok = (m_left == 0 && in_ie && in_ready && cand > lvl) ? 1 : 0;
`ifndef INT_NEST_EN
    if (lvl != 0) ok = 0;
`endif
    if (in_eret && lvl > 0) m_isr[lvl-1] = 0;
    if (ok != 0) begin
      m_isr[cand-1] = 1;
      m_pend[cand-1] = 0;
    end
    for (int i = 0; i < NSRC; i++) begin
      rq = in_req[i] ? 1 : 0;
      if (rq == 1 && m_req[i] == 0) m_pend[i] = 1;
      m_req[i] = rq;
      if (in_mask_we) m_mask[i] = in_mask[i] ? 1 : 0;
    end
    if (ok != 0) m_left = 1 + HOLD_CYC;
    else if (m_left > 0) m_left--;
    e_bk = ok;
    e_code = (ok != 0) ? cand : 0;
  endtask

  task automatic cyc();
    @(posedge in_CLK);
    model_step();
    #1;
    chk("bk", out_BK, e_bk);
    chk("code", out_code, e_code);
    chk("pending", out_pending, pack(m_pend));
    chk("isr", out_isr, pack(m_isr));
    chk("busy", out_busy, (m_left != 0) ? 1 : 0);
  endtask

  task automatic run(int n, output int first_code, output int nbk);
    first_code = 0; nbk = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      if (out_BK) begin
        if (nbk == 0) first_code = out_code;
        nbk++;
      end
    end
  endtask

  task automatic do_reset();
    in_RST = 1'b1; in_req = '0; in_mask_we = 1'b0; in_mask = '1;
    in_ie = 1'b1; in_ready = 1'b1; in_eret = 1'b0;
    cyc();
    in_RST = 1'b0;
  endtask

  initial begin
    int fc, nb, busy_n;

    // 1: single source, latency and blanking length
    do_reset();
    chk("rst_isr", out_isr, 0);
    chk("rst_pend", out_pending, 0);
    in_req = 3'b001;
    cyc();
    chk("t1_pend", out_pending, 1);
    cyc();
    chk("t1_bk", out_BK, 1);
    chk("t1_code", out_code, 1);
    chk("t1_isr", out_isr, 1);
    in_req = '0;
    busy_n = out_busy ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (out_busy) busy_n++;
    end
    chk("t1_busy_len", busy_n, 1 + HOLD_CYC);

    // 2: simultaneous edges, higher first, lower after eret
    do_reset();
    in_req = 3'b011;
    cyc();
    in_req = '0;
    run(6, fc, nb);
    chk("t2_first", fc, 2);
    chk("t2_nbk", nb, 1);
    in_eret = 1'b1;
    cyc();
    in_eret = 1'b0;
    run(6, fc, nb);
    chk("t2_second", fc, 1);

    // 3: preemption attempt on top of an active handler
    do_reset();
    in_req = 3'b001;
    run(5, fc, nb);
    in_req = 3'b100;
    run(5, fc, nb);
`ifdef INT_NEST_EN
    chk("t3_code", fc, 3);
    chk("t3_isr", out_isr, 5);
`else
    chk("t3_nbk", nb, 0);
    chk("t3_isr", out_isr, 1);
`endif
    in_req = '0;
    in_eret = 1'b1;
    cyc();
    in_eret = 1'b0;
    run(5, fc, nb);
    in_eret = 1'b1;
    cyc();
    in_eret = 1'b0;
    run(5, fc, nb);

    // 4: masked source waits, unmask dispatches
    do_reset();
    in_mask = 3'b110; in_mask_we = 1'b1;
    cyc();
    in_mask_we = 1'b0; in_req = 3'b001;
    cyc();
    in_req = '0;
    run(5, fc, nb);
    chk("t4_nbk", nb, 0);
    chk("t4_pend", out_pending, 1);
    in_mask = 3'b111; in_mask_we = 1'b1;
    cyc();
    in_mask_we = 1'b0;
    run(4, fc, nb);
    chk("t4_code", fc, 1);

    // 5: stalled by ie / ready
    do_reset();
    in_ie = 1'b0; in_req = 3'b100;
    run(5, fc, nb);
    chk("t5_ie_nbk", nb, 0);
    in_ie = 1'b1;
    cyc();
    chk("t5_ie_bk", out_BK, 1);
    do_reset();
    in_ready = 1'b0; in_req = 3'b100;
    run(5, fc, nb);
    chk("t5_rdy_nbk", nb, 0);
    in_ready = 1'b1;
    cyc();
    chk("t5_rdy_bk", out_BK, 1);

    // 6: reset during BREAK
    do_reset();
    in_req = 3'b110;
    cyc();
    cyc();
    in_RST = 1'b1;
    cyc();
    chk("t6_pend", out_pending, 0);
    chk("t6_isr", out_isr, 0);
    chk("t6_busy", out_busy, 0);
    in_RST = 1'b0; in_req = '0; in_eret = 1'b1;
    cyc();
    in_eret = 1'b0;
    chk("t6_eret_isr", out_isr, 0);

    // random traffic
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      in_RST = ($urandom_range(0, 299) == 0);
      for (int i = 0; i < NSRC; i++)
        if ($urandom_range(0, 5) == 0) in_req[i] = ~in_req[i];
      in_eret    = ($urandom_range(0, 6) == 0);
      in_ie      = ($urandom_range(0, 4) != 0);
      in_ready   = ($urandom_range(0, 4) != 0);
      in_mask_we = ($urandom_range(0, 15) == 0);
      in_mask    = NSRC'($urandom);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
